// File: rtl/pcs_rx_block_lock.sv
// ---------------------------------------------------------------------------
// pcs_rx_block_lock
//   10GBASE-R receive block-synchronisation controller. Watches the 2-bit
//   sync header of each 66b block coming out of the RX gearbox, requests
//   one-bit slips until header alignment is found, and declares block_lock
//   for the descrambler/decoder.
//
// Ports
//   CLK             receive clock, rising edge
//   RST             synchronous active-high reset
//   signal_ok       PMA signal present; low forces the unlocked initial state
//   hdr_valid       rx_header carries a new block header this cycle
//   rx_header       sync header (01 data, 10 control, 00/11 invalid)
//   block_lock      header alignment achieved
//   slip            one-cycle request to the gearbox to shift by one bit
//   sh_cnt          headers seen in the current window (debug)
//   sh_invalid_cnt  invalid headers seen in the current window (debug)
//   slip_count      slips since reset, saturating at all-ones
//
// States
//   state        | meaning
//   ST_COUNT     | counting headers in a test window
//   ST_SLIP_WAIT | slip issued; headers ignored while the gearbox settles
// ---------------------------------------------------------------------------
module pcs_rx_block_lock #(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT_CYC  = 4,
  parameter int SLIP_CNT_W     = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  signal_ok,
  input  logic                  hdr_valid,
  input  logic [1:0]            rx_header,
  output logic                  block_lock,
  output logic                  slip,
  output logic [6:0]            sh_cnt,
  output logic [4:0]            sh_invalid_cnt,
  output logic [SLIP_CNT_W-1:0] slip_count
);

  localparam int WAIT_W = (SLIP_WAIT_CYC > 1) ? $clog2(SLIP_WAIT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SLIP_WAIT_CYC - 1);
  localparam logic [7:0] CNT_END = 8'(SH_CNT_MAX);
  localparam logic [5:0] INV_END = 6'(SH_INVALID_MAX);

  typedef enum logic {
    ST_COUNT,
    ST_SLIP_WAIT
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic       sh_ok;
  logic [7:0] n_hdr;
  logic [5:0] n_inv;
  logic       slip_sat;
  logic       do_slip;
  logic       win_end;

  // Widened by one bit so the window-end and invalid-limit compares never
  // see a wrapped value.
  always_comb begin
    sh_ok    = rx_header[1] ^ rx_header[0];
    n_hdr    = {1'b0, sh_cnt} + 8'd1;
    n_inv    = {1'b0, sh_invalid_cnt} + {5'd0, ~sh_ok};
    slip_sat = &slip_count;
    do_slip  = !sh_ok && (!block_lock || (n_inv == INV_END));
    win_end  = (n_hdr == CNT_END);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= ST_COUNT;
      wait_cnt       <= '0;
      block_lock     <= 1'b0;
      slip           <= 1'b0;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
      slip_count     <= '0;
    end else if (!signal_ok) begin
      // Loss of signal restarts acquisition but keeps the slip history.
      state          <= ST_COUNT;
      wait_cnt       <= '0;
      block_lock     <= 1'b0;
      slip           <= 1'b0;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
    end else begin
      case (state)
        ST_COUNT: begin
          slip <= 1'b0;
          if (hdr_valid) begin
            if (do_slip) begin
              // Slip takes precedence even when this is also the last
              // header of the window.
              block_lock     <= 1'b0;
              slip           <= 1'b1;
              sh_cnt         <= '0;
              sh_invalid_cnt <= '0;
              if (!slip_sat) slip_count <= slip_count + 1'b1;
              wait_cnt       <= WAIT_INIT;
              state          <= ST_SLIP_WAIT;
            end else if (win_end) begin
              if (n_inv == 6'd0) block_lock <= 1'b1;
              sh_cnt         <= '0;
              sh_invalid_cnt <= '0;
            end else begin
              sh_cnt         <= n_hdr[6:0];
              sh_invalid_cnt <= n_inv[4:0];
            end
          end
        end
        ST_SLIP_WAIT: begin
          // slip was raised on entry; drop it after its single cycle.
          slip <= 1'b0;
          if (wait_cnt == '0) begin
            state <= ST_COUNT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_COUNT;
          slip  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
module tb_pcs_rx_block_lock;

  logic        CLK;
  logic        RST;
  logic        signal_ok;
  logic        hdr_valid;
  logic [1:0]  rx_header;
  logic        block_lock;
  logic        slip;
  logic [6:0]  sh_cnt;
  logic [4:0]  sh_invalid_cnt;
  logic [15:0] slip_count;

  logic        s_block_lock;
  logic        s_slip;
  logic [6:0]  s_sh_cnt;
  logic [4:0]  s_sh_invalid_cnt;
  logic [3:0]  s_slip_count;

  int checks   = 0;
  int failures = 0;
  int exp_slips = 0;
  logic slip_seen;

  pcs_rx_block_lock dut (
    .CLK(CLK), .RST(RST), .signal_ok(signal_ok), .hdr_valid(hdr_valid),
    .rx_header(rx_header), .block_lock(block_lock), .slip(slip),
    .sh_cnt(sh_cnt), .sh_invalid_cnt(sh_invalid_cnt), .slip_count(slip_count)
  );

  // Narrow slip counter so saturation is reachable in a short run.
  pcs_rx_block_lock #(.SLIP_CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .signal_ok(signal_ok), .hdr_valid(hdr_valid),
    .rx_header(rx_header), .block_lock(s_block_lock), .slip(s_slip),
    .sh_cnt(s_sh_cnt), .sh_invalid_cnt(s_sh_invalid_cnt),
    .slip_count(s_slip_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and sample just after the deciding edge.
  task automatic cyc(input logic ok, input logic v, input logic [1:0] h);
    @(negedge CLK);
    signal_ok = ok;
    hdr_valid = v;
    rx_header = h;
    @(posedge CLK);
    #1;
    if (slip) slip_seen = 1'b1;
  endtask

  // Slip pulse followed by the three further ignored cycles.
  task automatic do_slip_and_wait();
    cyc(1, 1, 2'b00);
    exp_slips++;
    repeat (4) cyc(1, 1, 2'b01);
  endtask

  initial begin
    RST = 1'b1; signal_ok = 1'b1; hdr_valid = 1'b0; rx_header = 2'b00;
    slip_seen = 1'b0;
    cyc(1, 0, 2'b00);
    cyc(1, 0, 2'b00);
    RST = 1'b0;
    check("rst_lock", block_lock, 0);
    check("rst_slip", slip, 0);
    check("rst_sh_cnt", sh_cnt, 0);
    check("rst_inv", sh_invalid_cnt, 0);
    check("rst_slip_count", slip_count, 0);

    // First lock: 64 valid headers.
    repeat (63) cyc(1, 1, 2'b01);
    check("lock_pre_lock", block_lock, 0);
    check("lock_pre_cnt", sh_cnt, 63);
    cyc(1, 1, 2'b10);
    check("lock_lock", block_lock, 1);
    check("lock_cnt_clr", sh_cnt, 0);
    check("lock_no_slip", slip_seen, 0);

    // Hold idle cycles: no change.
    repeat (3) cyc(1, 0, 2'b00);
    check("idle_cnt", sh_cnt, 0);

    // 15 invalid headers in a window: lock holds.
    for (int i = 0; i < 63; i++) cyc(1, 1, (i < 15) ? 2'b11 : 2'b01);
    check("inv15_cnt", sh_cnt, 63);
    check("inv15_inv", sh_invalid_cnt, 15);
    cyc(1, 1, 2'b01);
    check("inv15_lock", block_lock, 1);
    check("inv15_inv_clr", sh_invalid_cnt, 0);
    check("inv15_no_slip", slip_seen, 0);
    repeat (64) cyc(1, 1, 2'b01);
    check("clean_win_lock", block_lock, 1);

    // One invalid header in a window.
    for (int i = 0; i < 64; i++) cyc(1, 1, (i == 10) ? 2'b00 : 2'b10);
    check("inv1_lock", block_lock, 1);
    check("inv1_cnt", sh_cnt, 0);
    check("inv1_inv", sh_invalid_cnt, 0);

    // 64th header is also the 16th invalid: slip wins.
    for (int i = 0; i < 63; i++) cyc(1, 1, (i < 48) ? 2'b01 : 2'b11);
    check("inv16_pre_lock", block_lock, 1);
    check("inv16_pre_inv", sh_invalid_cnt, 15);
    check("inv16_pre_slip", slip, 0);
    cyc(1, 1, 2'b11);
    exp_slips++;
    check("inv16_slip", slip, 1);
    check("inv16_lock", block_lock, 0);
    check("inv16_slip_count", slip_count, exp_slips);
    check("inv16_cnt", sh_cnt, 0);
    cyc(1, 1, 2'b01);
    check("slip_width", slip, 0);
    repeat (3) cyc(1, 1, 2'b01);
    check("wait_ignored", sh_cnt, 0);
    cyc(1, 1, 2'b01);
    check("wait_resume", sh_cnt, 1);

    // Unlocked: a single invalid header slips immediately.
    cyc(1, 1, 2'b00);
    exp_slips++;
    check("unl_slip", slip, 1);
    check("unl_slip_count", slip_count, exp_slips);
    check("unl_cnt", sh_cnt, 0);
    repeat (4) cyc(1, 1, 2'b01);
    check("unl_wait_cnt", sh_cnt, 0);
    repeat (64) cyc(1, 1, 2'b01);
    check("relock", block_lock, 1);

    // signal_ok drop mid-window.
    repeat (10) cyc(1, 1, 2'b01);
    cyc(1, 1, 2'b11);
    check("sig_pre_cnt", sh_cnt, 11);
    check("sig_pre_inv", sh_invalid_cnt, 1);
    cyc(0, 1, 2'b01);
    check("sig_lock", block_lock, 0);
    check("sig_cnt", sh_cnt, 0);
    check("sig_inv", sh_invalid_cnt, 0);
    check("sig_slip_count", slip_count, exp_slips);
    repeat (64) cyc(1, 1, 2'b01);
    check("sig_relock", block_lock, 1);

    // Reset during slip wait.
    repeat (16) cyc(1, 1, 2'b00);
    check("rw_slip", slip, 1);
    RST = 1'b1;
    cyc(1, 1, 2'b01);
    RST = 1'b0;
    exp_slips = 0;
    check("rw_lock", block_lock, 0);
    check("rw_slip_clr", slip, 0);
    check("rw_slip_count", slip_count, 0);
    check("rw_cnt", sh_cnt, 0);
    cyc(1, 1, 2'b01);
    check("rw_resume", sh_cnt, 1);

    // Saturation on the narrow instance; the wide one keeps counting.
    repeat (15) do_slip_and_wait();
    check("sat_at_max", s_slip_count, 15);
    repeat (5) do_slip_and_wait();
    check("sat_hold", s_slip_count, 15);
    check("wide_count", slip_count, exp_slips);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
